// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - multi-cycle data-memory responder with fixed wait states
module dmem_responder #(
  parameter int ADDR_W      = 10,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [31:0] addr,
  input  logic [31:0] writeData,
  output logic [31:0] readData,
  output logic        memStall,
  output logic        memErr
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic                op_write_q, op_write_d;
  logic [ADDR_W-1:0]   idx_q, idx_d;
  logic [31:0]         wdata_q, wdata_d;
  logic [31:0]         read_data_q, read_data_d;
  logic                mem_err_q, mem_err_d;

  logic [31:0]         mem [0:(1<<ADDR_W)-1];

  logic                req_any;
  logic                req_valid;
  logic                req_invalid;
  logic                access_now;
  logic                mem_we;
  logic                unused_addr_bits;

  // A request is accepted only with exactly one strobe and a word-aligned address
  assign req_any     = MemRead | MemWrite;
  assign req_valid   = (MemRead ^ MemWrite) && (addr[1:0] == 2'b00);
  assign req_invalid = req_any && !req_valid;

  // The array is touched on the last BUSY edge, using only the latched request
  assign access_now  = (state_q == BUSY) && (cnt_q == 4'd1);
  assign mem_we      = access_now && op_write_q;

  // Address bits above the word index wrap and are deliberately ignored
  assign unused_addr_bits = ^addr[31:ADDR_W+2];

  // State register and latched request; reset aborts any access in flight
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= 4'd0;
      op_write_q  <= 1'b0;
      idx_q       <= '0;
      wdata_q     <= 32'h0;
      read_data_q <= 32'h0;
      mem_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      op_write_q  <= op_write_d;
      idx_q       <= idx_d;
      wdata_q     <= wdata_d;
      read_data_q <= read_data_d;
      mem_err_q   <= mem_err_d;
    end
  end

  // Next-state and datapath: accept in IDLE, count down in BUSY, one DONE cycle
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    op_write_d  = op_write_q;
    idx_d       = idx_q;
    wdata_d     = wdata_q;
    read_data_d = read_data_q;
    mem_err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          state_d    = BUSY;
          cnt_d      = 4'(WAIT_CYCLES);
          op_write_d = MemWrite;
          idx_d      = addr[ADDR_W+1:2];
          wdata_d    = writeData;
        end else if (req_invalid) begin
          mem_err_d  = 1'b1;
        end
      end
      BUSY: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d = DONE;
          if (!op_write_q) begin
            read_data_d = mem[idx_q];
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Outputs: stall covers the accepting IDLE cycle and all of BUSY, never reset
  always_comb begin
    memStall = 1'b0;
    if (!reset) begin
      memStall = ((state_q == IDLE) && req_valid) || (state_q == BUSY);
    end
    readData = read_data_q;
    memErr   = mem_err_q;
  end

  // Word array; contents survive reset and are written only on a completed store
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[idx_q] <= wdata_q;
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - randomized self-checking bench for dmem_responder
module tb_dmem_responder;

  logic        clk;
  logic        reset;
  logic        mem_read  [3];
  logic        mem_write [3];
  logic [31:0] addr      [3];
  logic [31:0] wdata     [3];
  logic [31:0] rdata     [3];
  logic        stall     [3];
  logic        err       [3];

  int          waits     [3];
  logic [31:0] ref_mem   [3][1024];
  logic [31:0] ref_rd    [3];

  int tests_run = 0;
  int failed    = 0;

  dmem_responder #(.ADDR_W(10), .WAIT_CYCLES(2)) u_w2 (
    .clk(clk), .reset(reset), .MemRead(mem_read[0]), .MemWrite(mem_write[0]),
    .addr(addr[0]), .writeData(wdata[0]), .readData(rdata[0]),
    .memStall(stall[0]), .memErr(err[0]));

  dmem_responder #(.ADDR_W(10), .WAIT_CYCLES(1)) u_w1 (
    .clk(clk), .reset(reset), .MemRead(mem_read[1]), .MemWrite(mem_write[1]),
    .addr(addr[1]), .writeData(wdata[1]), .readData(rdata[1]),
    .memStall(stall[1]), .memErr(err[1]));

  dmem_responder #(.ADDR_W(10), .WAIT_CYCLES(15)) u_w15 (
    .clk(clk), .reset(reset), .MemRead(mem_read[2]), .MemWrite(mem_write[2]),
    .addr(addr[2]), .writeData(wdata[2]), .readData(rdata[2]),
    .memStall(stall[2]), .memErr(err[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One full request from the requester's side; checks stall length and DONE data
  task automatic access(input int u, input bit rd, input bit wr,
                        input logic [31:0] a, input logic [31:0] d, input string name);
    int n;
    bit ok;
    ok = (rd ^ wr) && (a[1:0] == 2'b00);
    @(negedge clk);
    mem_read[u] = rd; mem_write[u] = wr; addr[u] = a; wdata[u] = d;
    #1;
    if (ok) begin
      n = 0;
      while (stall[u] === 1'b1 && n < 40) begin
        n++;
        @(negedge clk);
        addr[u] = $urandom();
        wdata[u] = $urandom();
      end
      tests_run++;
      if (n !== waits[u] + 1) begin
        failed++;
        $display("FAIL %s stall_len: got %0d expected %0d", name, n, waits[u] + 1);
      end
      tests_run++;
      if (err[u] !== 1'b0) begin
        failed++;
        $display("FAIL %s err_in_done: got %b expected 0", name, err[u]);
      end
      if (rd) ref_rd[u] = ref_mem[u][a[11:2]];
      else ref_mem[u][a[11:2]] = d;
      tests_run++;
      if (rdata[u] !== ref_rd[u]) begin
        failed++;
        $display("FAIL %s done_rdata: got %h expected %h", name, rdata[u], ref_rd[u]);
      end
      mem_read[u] = 1'b0; mem_write[u] = 1'b0;
    end else begin
      tests_run++;
      if (stall[u] !== 1'b0) begin
        failed++;
        $display("FAIL %s bad_req_stall: got %b expected 0", name, stall[u]);
      end
      @(negedge clk);
      tests_run++;
      if (err[u] !== 1'b1 || rdata[u] !== ref_rd[u]) begin
        failed++;
        $display("FAIL %s err_pulse: err %b rdata %h expected err 1 rdata %h",
                 name, err[u], rdata[u], ref_rd[u]);
      end
      mem_read[u] = 1'b0; mem_write[u] = 1'b0;
      @(negedge clk);
      tests_run++;
      if (err[u] !== 1'b0 || stall[u] !== 1'b0) begin
        failed++;
        $display("FAIL %s err_clear: err %b stall %b expected 0 0", name, err[u], stall[u]);
      end
    end
  endtask

  task automatic check_reset_outputs(input string name);
    for (int u = 0; u < 3; u++) begin
      tests_run++;
      if (rdata[u] !== 32'h0 || stall[u] !== 1'b0 || err[u] !== 1'b0) begin
        failed++;
        $display("FAIL %s unit%0d: rdata %h stall %b err %b expected 0 0 0",
                 name, u, rdata[u], stall[u], err[u]);
      end
    end
  endtask

  task automatic test_reset;
    #3;
    check_reset_outputs("reset_state");
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_write_read;
    access(0, 1'b0, 1'b1, 32'h40, 32'hDEADBEEF, "wr_40");
    access(0, 1'b1, 1'b0, 32'h40, 32'h0, "rd_40");
    tests_run++;
    if (rdata[0] !== 32'hDEADBEEF) begin
      failed++;
      $display("FAIL rd_40_const: got %h expected deadbeef", rdata[0]);
    end
  endtask

  task automatic test_wrap;
    access(0, 1'b0, 1'b1, 32'h0000_1004, 32'h12345678, "wr_wrap");
    access(0, 1'b1, 1'b0, 32'h0000_0004, 32'h0, "rd_wrap");
    tests_run++;
    if (rdata[0] !== 32'h12345678) begin
      failed++;
      $display("FAIL rd_wrap_const: got %h expected 12345678", rdata[0]);
    end
  endtask

  task automatic test_invalid;
    access(0, 1'b1, 1'b0, 32'h42, 32'h0, "bad_misaligned");
    access(0, 1'b1, 1'b1, 32'h40, 32'h0BAD0BAD, "bad_both");
    access(0, 1'b0, 1'b1, 32'h43, 32'h0BAD0BAD, "bad_wr_misaligned");
    access(0, 1'b1, 1'b0, 32'h40, 32'h0, "rd_40_after_bad");
    tests_run++;
    if (rdata[0] !== 32'hDEADBEEF) begin
      failed++;
      $display("FAIL word40_intact: got %h expected deadbeef", rdata[0]);
    end
  endtask

  task automatic test_reset_mid_write;
    access(0, 1'b0, 1'b1, 32'h80, 32'h1, "wr_80_init");
    @(negedge clk);
    mem_write[0] = 1'b1; addr[0] = 32'h80; wdata[0] = 32'hAAAA5555;
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check_reset_outputs("reset_mid_write");
    mem_write[0] = 1'b0;
    for (int u = 0; u < 3; u++) ref_rd[u] = 32'h0;
    @(negedge clk);
    reset = 1'b0;
    access(0, 1'b1, 1'b0, 32'h80, 32'h0, "rd_80_after_reset");
    tests_run++;
    if (rdata[0] !== 32'h1) begin
      failed++;
      $display("FAIL write_discarded: got %h expected 00000001", rdata[0]);
    end
  endtask

  // Random mix of loads, stores and rejected requests over a small word pool
  task automatic test_random(input int u, input int nops);
    logic [31:0] r, a;
    logic [9:0]  idx;
    int          op;
    for (int k = 0; k < 8; k++) begin
      r = $urandom();
      idx = 10'h100 + 10'(k);
      access(u, 1'b0, 1'b1, {r[31:12], idx, 2'b00}, $urandom(), "rand_prefill");
    end
    for (int k = 0; k < nops; k++) begin
      r = $urandom();
      idx = 10'h100 + 10'($urandom_range(0, 7));
      a = {r[31:12], idx, 2'b00};
      op = $urandom_range(0, 5);
      case (op)
        0, 1, 2: access(u, 1'b1, 1'b0, a, 32'h0, "rand_rd");
        3, 4:    access(u, 1'b0, 1'b1, a, $urandom(), "rand_wr");
        default: begin
          if (r[0]) access(u, 1'b1, 1'b1, a, $urandom(), "rand_both");
          else access(u, r[1], !r[1], a | 32'(r[3:2] == 2'b00 ? 2'b01 : r[3:2]),
                      $urandom(), "rand_misaligned");
        end
      endcase
    end
  endtask

  task automatic test_stall_sweep;
    test_random(1, 20);
    test_random(2, 12);
    test_random(0, 20);
  endtask

  task automatic test_back_to_back;
    access(1, 1'b0, 1'b1, 32'h200, 32'hCAFEF00D, "b2b_wr");
    access(1, 1'b1, 1'b0, 32'h200, 32'h0, "b2b_rd");
    access(1, 1'b0, 1'b1, 32'h200, 32'h5A5A5A5A, "b2b_wr2");
    access(1, 1'b1, 1'b0, 32'h200, 32'h0, "b2b_rd2");
  endtask

  initial begin
    waits[0] = 2; waits[1] = 1; waits[2] = 15;
    reset = 1'b1;
    for (int u = 0; u < 3; u++) begin
      mem_read[u] = 1'b0; mem_write[u] = 1'b0;
      addr[u] = 32'h0; wdata[u] = 32'h0; ref_rd[u] = 32'h0;
    end
    test_reset();
    test_write_read();
    test_wrap();
    test_invalid();
    test_back_to_back();
    test_reset_mid_write();
    test_stall_sweep();
    $display("[TB] %0d tests run, %0d failed", tests_run, failed);
    $finish;
  end

endmodule
